bch_host_feeder: RTL

Host-side initiator for the `bch` decoder's set/ready/finish protocol. It starts each frame by pulsing `set` with the selected `mode`/`code`, and streams 64-bit codeword words from an external asynchronous-read word memory whenever the decoder raises `ready`. It forwards every `odata` value seen under `finish` to the host, and sequences `nframes` frames back to back with a fixed idle gap between them. It sits between the system's word buffer and `bch`, and replaces the bench-side driver in integrated builds.

---
 rtl/bch_host_pkg.sv | 31 +++
 rtl/bch_host_feeder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bch_host_pkg.sv
// Shared types and defaults for the bch host-side feeder: FSM state encoding,
// timing defaults and the per-frame word budget.
package bch_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int unsigned GAP_CYCLES_DEF = 10;
    localparam int unsigned TIMEOUT_DEF    = 65535;

    // Soft decision carries eight times the words of hard decision for the same code.
    function automatic logic [7:0] words_per_frame(input logic mode, input logic [1:0] code);
        logic [7:0] w;
        case (code)
            2'd1:    w = 8'd1;
            2'd2:    w = 8'd4;
            2'd3:    w = 8'd16;
            default: w = 8'd0;
        endcase
        if (mode) begin
            w = w << 3;
        end
        return w;
    endfunction

endpackage

// File: rtl/bch_host_feeder.sv
// Host-side initiator for the bch decoder: pulses set per frame, streams words
// from an async-read memory on ready, forwards results and sequences frames.
module bch_host_feeder
    import bch_host_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned AW         = 13
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          start_mode,
    input  logic [1:0]    start_code,
    input  logic [7:0]    nframes,
    output logic [AW-1:0] mem_addr,
    input  logic [63:0]   mem_rdata,
    output logic          set,
    output logic          mode,
    output logic [1:0]    code,
    output logic [63:0]   idata,
    input  logic          ready,
    input  logic          finish,
    input  logic [9:0]    odata,
    output logic          busy,
    output logic          res_valid,
    output logic [9:0]    res_data,
    output logic          frame_done,
    output logic          done,
    output logic          err_over,
    output logic          err_under,
    output logic          err_tmo
);

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    nf_q, nf_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [15:0]   gap_q, gap_d;
    logic          seen_q, seen_d;
    logic [63:0]   idata_q, idata_d;
    logic          res_valid_q, res_valid_d;
    logic [9:0]    res_data_q, res_data_d;
    logic          frame_done_q, frame_done_d;
    logic          over_q, over_d;
    logic          under_q, under_d;
    logic          tmo_err_q, tmo_err_d;
    logic [7:0]    wpf;

    assign wpf = words_per_frame(mode_q, code_q);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        code_d       = code_q;
        nf_d         = nf_q;
        fcnt_d       = fcnt_q;
        ptr_d        = ptr_q;
        wcnt_d       = wcnt_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        seen_d       = seen_q;
        idata_d      = idata_q;
        res_valid_d  = 1'b0;
        res_data_d   = res_data_q;
        frame_done_d = 1'b0;
        over_d       = over_q;
        under_d      = under_q;
        tmo_err_d    = tmo_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d    = start_mode;
                    code_d    = start_code;
                    nf_d      = nframes;
                    ptr_d     = '0;
                    fcnt_d    = '0;
                    over_d    = 1'b0;
                    under_d   = 1'b0;
                    tmo_err_d = 1'b0;
                    state_d   = (nframes == 8'd0) ? ST_DONE : ST_SET;
                end
            end
            ST_SET: begin
                wcnt_d  = '0;
                tmo_d   = '0;
                seen_d  = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                tmo_d = tmo_q + 32'd1;
                // Overrun words are still supplied so the decoder never stalls.
                if (ready) begin
                    idata_d = mem_rdata;
                    ptr_d   = ptr_q + 1'b1;
                    if (wcnt_q != '1) begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                    if (wcnt_q >= wpf) begin
                        over_d = 1'b1;
                    end
                end
                if (finish) begin
                    res_valid_d = 1'b1;
                    res_data_d  = odata;
                    seen_d      = 1'b1;
                end else if (seen_q) begin
                    frame_done_d = 1'b1;
                    if (wcnt_d < wpf) begin
                        under_d = 1'b1;
                    end
                    fcnt_d  = fcnt_q + 8'd1;
                    gap_d   = '0;
                    state_d = ((fcnt_q + 8'd1) == nf_q) ? ST_DONE : ST_GAP;
                end
                if (tmo_d == TIMEOUT) begin
                    tmo_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_GAP: begin
                if (ready) begin
                    over_d = 1'b1;
                end
                if (gap_q == 16'(GAP_CYCLES)) begin
                    state_d = ST_SET;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            code_q       <= '0;
            nf_q         <= '0;
            fcnt_q       <= '0;
            ptr_q        <= '0;
            wcnt_q       <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            seen_q       <= 1'b0;
            idata_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            frame_done_q <= 1'b0;
            over_q       <= 1'b0;
            under_q      <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            code_q       <= code_d;
            nf_q         <= nf_d;
            fcnt_q       <= fcnt_d;
            ptr_q        <= ptr_d;
            wcnt_q       <= wcnt_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            seen_q       <= seen_d;
            idata_q      <= idata_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            frame_done_q <= frame_done_d;
            over_q       <= over_d;
            under_q      <= under_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign mem_addr   = ptr_q;
    assign set        = (state_q == ST_SET);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign mode       = mode_q;
    assign code       = code_q;
    assign idata      = idata_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign frame_done = frame_done_q;
    assign err_over   = over_q;
    assign err_under  = under_q;
    assign err_tmo    = tmo_err_q;

endmodule
